// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional macro UART_ARB_PRIORITY_EN makes requester 0 high priority.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ID_W          = 2,
   parameter int START_TIMEOUT = 4096,
   parameter int GAP_CYCLES    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*8-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   tx_busy,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   output logic [ID_W-1:0]        grant_id,
   output logic                   arb_busy,
   output logic                   timeout_err
);

   localparam int LW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN, GAP} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [LW-1:0]     launch_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   idx;
   logic [NUM_REQ-1:0] scan_mask;
   logic              found;
   logic              grant;
   logic [7:0]        sel_data;

`ifdef UART_ARB_PRIORITY_EN
   logic              prev_zero;
`endif

   // Scan from the requester after the last winner, wrapping, so the last winner is served last.
   always_comb begin
      winner    = '0;
      idx       = '0;
      found     = 1'b0;
      scan_mask = req_valid;
`ifdef UART_ARB_PRIORITY_EN
      // Requester 0 yields one turn after winning so the others are not starved.
      if (req_valid[0] && (!prev_zero || req_valid[NUM_REQ-1:1] == '0)) begin
         winner = '0;
         found  = 1'b1;
      end else begin
         scan_mask[0] = 1'b0;
      end
`endif
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && scan_mask[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) sel_data = req_data[i*8 +: 8];
      end
   end

   assign grant     = (state == IDLE) && !tx_busy && (|req_valid) && !reset;
   assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= ID_W'(NUM_REQ - 1);
         launch_cnt  <= '0;
         gap_cnt     <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         grant_id    <= '0;
         arb_busy    <= 1'b0;
         timeout_err <= 1'b0;
`ifdef UART_ARB_PRIORITY_EN
         prev_zero   <= 1'b0;
`endif
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  tx_data    <= sel_data;
                  grant_id   <= winner;
                  tx_start   <= 1'b1;
                  arb_busy   <= 1'b1;
                  launch_cnt <= '0;
                  state      <= LAUNCH;
`ifdef UART_ARB_PRIORITY_EN
                  if (winner == '0) begin
                     prev_zero <= 1'b1;
                  end else begin
                     ptr       <= winner;
                     prev_zero <= 1'b0;
                  end
`else
                  ptr        <= winner;
`endif
               end
            end
            LAUNCH: begin
               if (tx_busy) begin
                  tx_start <= 1'b0;
                  state    <= DRAIN;
               end else if (launch_cnt == LW'(START_TIMEOUT - 1)) begin
                  // Transmitter never answered: drop the byte and fall into the gap.
                  tx_start    <= 1'b0;
                  timeout_err <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end else begin
                  launch_cnt <= launch_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (!tx_busy) begin
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (GAP_CYCLES == 0 || gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  arb_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               arb_busy <= 1'b0;
               tx_start <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
